requant_scheduler: RTL and testbench
====================================

# requant_scheduler

Shares one Int32→Int8 requantizer (32-bit accumulator in, m0 multiplier plus n right-shift, 8-bit result out) among NUM_CH accumulator channels of the CNN output stage. It holds per-channel (m0, n) configuration, arbitrates channel requests round-robin, and issues one operand per cycle together with that channel's scaling pair. Each result is tagged with its source channel and buffered, so results are never dropped when the consumer stalls.

## Interface
- NUM_CH, 4, number of requesting channels (≥2)
- IN_W, 32, accumulator and m0 width
- OUT_W, 8, requantized result width
- MAX_INFLIGHT, 4, credit pool; also output FIFO depth (power of 2)
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- cfg_we_i  in  1  config write strobe
- cfg_ch_i  in  $clog2(NUM_CH)  channel being configured
- cfg_m0_i  in  IN_W  multiplier value
- cfg_n_i  in  4  shift value
- req_valid_i  in  NUM_CH  per-channel operand valid
- req_data_i  in  NUM_CH*IN_W  per-channel operands, channel k at [k*IN_W +: IN_W]
- req_ready_o  out  NUM_CH  per-channel grant (one-hot or zero)
- rq_valid_o  out  1  operand valid to requantizer
- rq_data_o  out  IN_W  operand to requantizer
- rq_m0_o  out  IN_W  m0 of the issued channel
- rq_n_o  out  4  n of the issued channel
- rq_ready_o  out  1  ready to requantizer, tied 1
- rq_valid_i  in  1  requantizer result valid
- rq_data_i  in  OUT_W  requantizer result
- out_valid_o  out  1  tagged result available
- out_data_o  out  OUT_W  result
- out_ch_o  out  $clog2(NUM_CH)  source channel of the result
- out_ready_i  in  1  consumer accepts result
- err_o  out  1  sticky: result arrived with no outstanding tag

## Operation
- Config: per-channel m0/n registers, written on a rising edge when cfg_we_i=1. Reset value is 0 for both fields.
- Credits:
  - credit = MAX_INFLIGHT − (tags outstanding + output FIFO occupancy).
  - An issue consumes one credit. An output pop (out_valid_o & out_ready_i) returns one.
  - No grant is made while credit = 0.
- Arbiter:
  - Round-robin. The priority pointer starts at channel 0 after reset.
  - After a grant to channel k, the pointer moves to (k+1) mod NUM_CH. The pointer does not move when there is no grant.
  - req_ready_o is combinational from req_valid_i, pointer and credit. At most one bit is set per cycle.
  - A channel may hold req_valid_i high and receives back-to-back grants only when it is the sole requester.
- Issue stage:
  - On a handshake of channel k, rq_data_o, rq_m0_o and rq_n_o are registered from channel k's operand and its config as it stood before that edge.
  - A config write in the same cycle as the grant does not affect that issue.
  - rq_valid_o is high for exactly one cycle per handshake.
  - k is pushed into a tag FIFO of depth MAX_INFLIGHT, in issue order.
- Return:
  - On rq_valid_i, the head tag is popped and {tag, rq_data_i} is pushed into the output FIFO.
  - Results are assumed in issue order; any requantizer latency is allowed.
  - If rq_valid_i arrives while the tag FIFO is empty: err_o is set, the result is discarded, and no push occurs.
- Output FIFO: first-word fall-through. out_valid_o = not empty. Simultaneous push and pop is allowed. By construction, the output FIFO never overflows.
- Issue and return may occur in the same cycle. Tag push and tag pop in the same cycle are legal, including when the tag FIFO is full.

## Timing
- Reset (asynchronous):
  - Cleared: req_ready_o=0, rq_valid_o=0, rq_data_o=0, rq_m0_o=0, rq_n_o=0, out_valid_o=0, out_data_o=0, out_ch_o=0, err_o=0.
  - Pointer=0, credit=MAX_INFLIGHT, FIFOs empty, config=0.
  - rq_ready_o=1 always.
- The requantizer shares rst_ni. Reset mid-operation discards all in-flight work and buffered results.
- Latency: handshake at edge T → rq_valid_o high in cycle T+1. rq_valid_i sampled at edge R → out_valid_o high in cycle R+1.
- Throughput: one issue per cycle while credit > 0.

## Test plan
Bench stub: a requantizer that returns rq_data_o[7:0] two cycles after rq_valid_o.
1. Config ch0 with m0=32'h8913_5389, n=7; ch0 sends 583 → rq_valid_o one cycle later with rq_data_o=583, rq_m0_o=32'h8913_5389, rq_n_o=7; then out_ch_o=0, out_data_o=8'h47.
2. All four channels hold valid constantly, out_ready_i=1 → grants in order 0,1,2,3,0…; out_ch_o follows the same order.
3. out_ready_i=0, channels 0 and 1 requesting → exactly 4 issues, then req_ready_o=0. Raise out_ready_i → each pop re-enables one grant; no result is lost.
4. Config write of n=3 to ch2 in the same cycle as a ch2 grant → that issue carries the old n. The next ch2 issue carries n=3.
5. Inject rq_valid_i with no outstanding issue → err_o=1 and held; out_valid_o stays 0.
6. Assert rst_ni low with 3 results in flight → all outputs return to reset values and credit=4. After release, the ch1 request is granted first only if ch0 is idle.

Source files
------------

// File: rtl/requant_scheduler.sv
// Shares one Int32->Int8 requantizer among NUM_CH channels. It keeps per-channel (m0, n) config,
// grants requests round-robin under a credit limit, and buffers tagged results in a FWFT FIFO.
module requant_scheduler #(
    parameter int NUM_CH       = 4,
    parameter int IN_W         = 32,
    parameter int OUT_W        = 8,
    parameter int MAX_INFLIGHT = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      cfg_we_i,
    input  logic [$clog2(NUM_CH)-1:0] cfg_ch_i,
    input  logic [IN_W-1:0]           cfg_m0_i,
    input  logic [3:0]                cfg_n_i,
    input  logic [NUM_CH-1:0]         req_valid_i,
    input  logic [NUM_CH*IN_W-1:0]    req_data_i,
    output logic [NUM_CH-1:0]         req_ready_o,
    output logic                      rq_valid_o,
    output logic [IN_W-1:0]           rq_data_o,
    output logic [IN_W-1:0]           rq_m0_o,
    output logic [3:0]                rq_n_o,
    output logic                      rq_ready_o,
    input  logic                      rq_valid_i,
    input  logic [OUT_W-1:0]          rq_data_i,
    output logic                      out_valid_o,
    output logic [OUT_W-1:0]          out_data_o,
    output logic [$clog2(NUM_CH)-1:0] out_ch_o,
    input  logic                      out_ready_i,
    output logic                      err_o
);
    localparam int CW = $clog2(NUM_CH);
    localparam int DW = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
    localparam int QW = DW + 1;
    localparam int EW = CW + OUT_W;

    logic [IN_W-1:0]   r_m0 [NUM_CH];
    logic [3:0]        r_n  [NUM_CH];
    logic [CW-1:0]     r_ptr;
    logic              r_rq_valid;
    logic [IN_W-1:0]   r_rq_data;
    logic [IN_W-1:0]   r_rq_m0;
    logic [3:0]        r_rq_n;
    logic              r_err;

    logic [CW-1:0]     r_tag_mem [MAX_INFLIGHT];
    logic [DW-1:0]     r_tag_wr;
    logic [DW-1:0]     r_tag_rd;
    logic [QW-1:0]     r_tag_cnt;
    logic [EW-1:0]     r_out_mem [MAX_INFLIGHT];
    logic [DW-1:0]     r_out_wr;
    logic [DW-1:0]     r_out_rd;
    logic [QW-1:0]     r_out_cnt;

    logic [IN_W-1:0]   w_op [NUM_CH];
    logic [NUM_CH-1:0] w_gnt;
    logic [CW-1:0]     w_gnt_ch;
    logic [CW:0]       w_idx;
    logic              w_found;
    logic [QW:0]       w_used;
    logic              w_credit_ok;
    logic              w_tag_pop;
    logic              w_err_set;
    logic              w_out_pop;
    logic [EW-1:0]     w_head;

    genvar g;
    generate
        for (g = 0; g < NUM_CH; g++) begin : g_op
            assign w_op[g] = req_data_i[g*IN_W +: IN_W];
        end
    endgenerate

    // Credits cover both results still in the requantizer and results waiting in the output FIFO.
    assign w_used      = {1'b0, r_tag_cnt} + {1'b0, r_out_cnt};
    assign w_credit_ok = (w_used < (QW+1)'(MAX_INFLIGHT));

    // Round-robin pick: first valid channel at or after the pointer, only while credit remains.
    always_comb begin
        w_gnt    = '0;
        w_gnt_ch = '0;
        w_found  = 1'b0;
        w_idx    = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_idx = {1'b0, r_ptr} + (CW+1)'(i);
            if (w_idx >= (CW+1)'(NUM_CH)) begin
                w_idx = w_idx - (CW+1)'(NUM_CH);
            end else begin
                w_idx = w_idx;
            end
            if (!w_found && w_credit_ok && req_valid_i[w_idx[CW-1:0]]) begin
                w_gnt[w_idx[CW-1:0]] = 1'b1;
                w_gnt_ch             = w_idx[CW-1:0];
                w_found              = 1'b1;
            end else begin
                w_found = w_found;
            end
        end
    end

    assign w_tag_pop = rq_valid_i && (r_tag_cnt != '0);
    assign w_err_set = rq_valid_i && (r_tag_cnt == '0);
    assign w_out_pop = out_valid_o && out_ready_i;

    // Per-channel scaling config; an issue in the same cycle still sees the old value.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < NUM_CH; k++) begin
                r_m0[k] <= '0;
                r_n[k]  <= '0;
            end
        end else if (cfg_we_i && (int'(cfg_ch_i) < NUM_CH)) begin
            r_m0[cfg_ch_i] <= cfg_m0_i;
            r_n[cfg_ch_i]  <= cfg_n_i;
        end
    end

    // Arbiter pointer and registered issue stage.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ptr      <= '0;
            r_rq_valid <= 1'b0;
            r_rq_data  <= '0;
            r_rq_m0    <= '0;
            r_rq_n     <= '0;
        end else begin
            r_rq_valid <= w_found;
            if (w_found) begin
                r_ptr     <= (w_gnt_ch == CW'(NUM_CH - 1)) ? '0 : w_gnt_ch + CW'(1);
                r_rq_data <= w_op[w_gnt_ch];
                r_rq_m0   <= r_m0[w_gnt_ch];
                r_rq_n    <= r_n[w_gnt_ch];
            end
        end
    end

    // FIFO storage; emptiness is tracked by the counters, so the arrays need no reset.
    always_ff @(posedge clk_i) begin
        if (w_found) begin
            r_tag_mem[r_tag_wr] <= w_gnt_ch;
        end
        if (w_tag_pop) begin
            r_out_mem[r_out_wr] <= {r_tag_mem[r_tag_rd], rq_data_i};
        end
    end

    // FIFO pointers, occupancy counters and the sticky orphan-result flag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_tag_wr  <= '0;
            r_tag_rd  <= '0;
            r_tag_cnt <= '0;
            r_out_wr  <= '0;
            r_out_rd  <= '0;
            r_out_cnt <= '0;
            r_err     <= 1'b0;
        end else begin
            if (w_found) begin
                r_tag_wr <= r_tag_wr + DW'(1);
            end
            if (w_tag_pop) begin
                r_tag_rd <= r_tag_rd + DW'(1);
                r_out_wr <= r_out_wr + DW'(1);
            end
            if (w_out_pop) begin
                r_out_rd <= r_out_rd + DW'(1);
            end
            if (w_err_set) begin
                r_err <= 1'b1;
            end
            r_tag_cnt <= r_tag_cnt + QW'(w_found) - QW'(w_tag_pop);
            r_out_cnt <= r_out_cnt + QW'(w_tag_pop) - QW'(w_out_pop);
        end
    end

    assign w_head      = r_out_mem[r_out_rd];
    assign out_valid_o = (r_out_cnt != '0);
    assign out_data_o  = out_valid_o ? w_head[OUT_W-1:0] : '0;
    assign out_ch_o    = out_valid_o ? w_head[EW-1:OUT_W] : '0;
    assign req_ready_o = w_gnt;
    assign rq_valid_o  = r_rq_valid;
    assign rq_data_o   = r_rq_data;
    assign rq_m0_o     = r_rq_m0;
    assign rq_n_o      = r_rq_n;
    assign rq_ready_o  = 1'b1;
    assign err_o       = r_err;
endmodule

// File: tb/tb_requant_scheduler.sv
// Bench for requant_scheduler: a two-cycle requantizer stub plus a transaction-level model
// (round-robin rule, credit = MAX_INFLIGHT - outstanding, in-order result queue).
module tb_requant_scheduler;
    localparam int NCH  = 4;
    localparam int MAXI = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         cfg_we = 1'b0;
    logic [1:0]   cfg_ch = 2'd0;
    logic [31:0]  cfg_m0 = 32'd0;
    logic [3:0]   cfg_n = 4'd0;
    logic [3:0]   req_valid = 4'd0;
    logic [127:0] req_data = 128'd0;
    logic [3:0]   req_ready;
    logic         rq_valid_o, rq_ready_o;
    logic [31:0]  rq_data_o, rq_m0_o;
    logic [3:0]   rq_n_o;
    logic         rq_valid_i;
    logic [7:0]   rq_data_i;
    logic         out_valid, out_ready = 1'b0;
    logic [7:0]   out_data;
    logic [1:0]   out_ch;
    logic         err;
    logic         inj = 1'b0;

    logic         s1_v, s2_v;
    logic [7:0]   s1_d, s2_d;

    int n_chk = 0;
    int n_fail = 0;

    logic [31:0]  m_m0 [NCH];
    logic [3:0]   m_n  [NCH];
    int           m_ptr;
    logic [9:0]   sb [$];
    logic         m_rq_v;
    logic [31:0]  m_rq_d, m_rq_m0;
    logic [3:0]   m_rq_n;
    logic         m_err;
    logic [3:0]   exp_gnt;

    always #5 clk = ~clk;

    requant_scheduler #(.NUM_CH(4), .IN_W(32), .OUT_W(8), .MAX_INFLIGHT(4)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .cfg_we_i(cfg_we), .cfg_ch_i(cfg_ch), .cfg_m0_i(cfg_m0), .cfg_n_i(cfg_n),
        .req_valid_i(req_valid), .req_data_i(req_data), .req_ready_o(req_ready),
        .rq_valid_o(rq_valid_o), .rq_data_o(rq_data_o), .rq_m0_o(rq_m0_o), .rq_n_o(rq_n_o),
        .rq_ready_o(rq_ready_o), .rq_valid_i(rq_valid_i), .rq_data_i(rq_data_i),
        .out_valid_o(out_valid), .out_data_o(out_data), .out_ch_o(out_ch),
        .out_ready_i(out_ready), .err_o(err)
    );

    // Requantizer stub: returns the low byte of the operand two cycles after rq_valid_o.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v <= 1'b0; s2_v <= 1'b0; s1_d <= 8'd0; s2_d <= 8'd0;
        end else begin
            s1_v <= rq_valid_o; s1_d <= rq_data_o[7:0];
            s2_v <= s1_v;       s2_d <= s1_d;
        end
    end
    assign rq_valid_i = s2_v | inj;
    assign rq_data_i  = inj ? 8'hA5 : s2_d;

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NCH; k++) begin
            m_m0[k] = 32'd0; m_n[k] = 4'd0;
        end
        m_ptr = 0; sb.delete(); m_rq_v = 1'b0; m_rq_d = 32'd0; m_rq_m0 = 32'd0;
        m_rq_n = 4'd0; m_err = 1'b0;
    endtask

    // Apply one cycle of inputs after the falling edge and predict the grant for that cycle.
    task automatic drive(input logic [3:0] v, input logic ordy, input logic we, input logic [1:0] ch,
                         input logic [31:0] m0, input logic [3:0] n, input logic ij,
                         input logic [127:0] d);
        int kk;
        @(negedge clk);
        req_valid = v; out_ready = ordy; cfg_we = we; cfg_ch = ch; cfg_m0 = m0; cfg_n = n;
        inj = ij; req_data = d;
        #1;
        exp_gnt = 4'd0;
        if (sb.size() < MAXI) begin
            for (int dd = 0; dd < NCH; dd++) begin
                kk = (m_ptr + dd) % NCH;
                if (exp_gnt == 4'd0 && v[kk]) exp_gnt[kk] = 1'b1;
            end
        end
    endtask

    // Advance the model across the coming rising edge.
    task automatic advance();
        if (out_valid && out_ready && sb.size() > 0) void'(sb.pop_front());
        if (inj && sb.size() == 0) m_err = 1'b1;
        m_rq_v = (exp_gnt != 4'd0);
        for (int k = 0; k < NCH; k++) begin
            if (exp_gnt[k]) begin
                sb.push_back({2'(k), req_data[k*32 +: 8]});
                m_ptr   = (k + 1) % NCH;
                m_rq_d  = req_data[k*32 +: 32];
                m_rq_m0 = m_m0[k];
                m_rq_n  = m_n[k];
            end
        end
        if (cfg_we) begin
            m_m0[cfg_ch] = cfg_m0; m_n[cfg_ch] = cfg_n;
        end
    endtask

    task automatic test_reset();
        model_reset();
        #12;
        n_chk++;
        if ({req_ready, rq_valid_o, rq_data_o, rq_m0_o, rq_n_o, out_valid, out_data, out_ch, err, rq_ready_o}
            !== {4'd0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b0, 8'd0, 2'd0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_state: got rdy=%b rqv=%b d=%h m0=%h n=%h ov=%b od=%h oc=%h err=%b rqr=%b",
                     req_ready, rq_valid_o, rq_data_o, rq_m0_o, rq_n_o, out_valid, out_data, out_ch, err, rq_ready_o);
        end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_single_issue();
        logic [127:0] d;
        bit seen;
        drive(4'd0, 1'b1, 1'b1, 2'd0, 32'h8913_5389, 4'd7, 1'b0, rnd128());
        advance();
        d = rnd128(); d[31:0] = 32'd583;
        drive(4'b0001, 1'b1, 1'b0, 2'd0, 32'd0, 4'd0, 1'b0, d);
        n_chk++;
        if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL single_grant: got %b want 0001", req_ready); end
        advance();
        drive(4'd0, 1'b1, 1'b0, 2'd0, 32'd0, 4'd0, 1'b0, rnd128());
        n_chk++;
        if ({rq_valid_o, rq_data_o, rq_m0_o, rq_n_o} !== {1'b1, 32'd583, 32'h8913_5389, 4'd7}) begin
            n_fail++;
            $display("FAIL single_issue: got v=%b d=%0d m0=%h n=%0d want v=1 d=583 m0=89135389 n=7",
                     rq_valid_o, rq_data_o, rq_m0_o, rq_n_o);
        end
        advance();
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            drive(4'd0, 1'b1, 1'b0, 2'd0, 32'd0, 4'd0, 1'b0, rnd128());
            if (out_valid) begin
                seen = 1'b1;
                n_chk++;
                if ({out_ch, out_data} !== {2'd0, 8'h47}) begin
                    n_fail++; $display("FAIL single_result: got ch=%0d data=%h want ch=0 data=47", out_ch, out_data);
                end
            end
            advance();
        end
        n_chk++;
        if (!seen) begin n_fail++; $display("FAIL single_timeout: got no result want one"); end
    endtask

    task automatic test_round_robin();
        int last, k;
        last = -1;
        for (int c = 0; c < 20; c++) begin
            drive(4'b1111, 1'b1, 1'b0, 2'd0, 32'd0, 4'd0, 1'b0, rnd128());
            n_chk++;
            if (req_ready !== exp_gnt) begin n_fail++; $display("FAIL rr_grant: got %b want %b", req_ready, exp_gnt); end
            if (out_valid) begin
                n_chk++;
                if (sb.size() == 0 || {out_ch, out_data} !== sb[0]) begin
                    n_fail++; $display("FAIL rr_result: got ch=%0d data=%h", out_ch, out_data);
                end
            end
            for (int j = 0; j < NCH; j++) begin
                if (req_ready[j]) begin
                    k = j;
                    if (last >= 0) begin
                        n_chk++;
                        if (k != (last + 1) % NCH) begin
                            n_fail++; $display("FAIL rr_order: got ch%0d want ch%0d", k, (last + 1) % NCH);
                        end
                    end
                    last = k;
                end
            end
            advance();
        end
        for (int c = 0; c < 40 && sb.size() > 0; c++) begin
            drive(4'd0, 1'b1, 1'b0, 2'd0, 32'd0, 4'd0, 1'b0, rnd128());
            if (out_valid) begin
                n_chk++;
                if (sb.size() == 0 || {out_ch, out_data} !== sb[0]) begin
                    n_fail++; $display("FAIL rr_drain: got ch=%0d data=%h", out_ch, out_data);
                end
            end
            advance();
        end
    endtask

    task automatic test_backpressure();
        int issued, popped;
        issued = 0; popped = 0;
        for (int c = 0; c < 10; c++) begin
            drive(4'b0011, 1'b0, 1'b0, 2'd0, 32'd0, 4'd0, 1'b0, rnd128());
            n_chk++;
            if (req_ready !== exp_gnt) begin n_fail++; $display("FAIL bp_grant: got %b want %b", req_ready, exp_gnt); end
            if (req_ready != 4'd0) issued++;
            advance();
        end
        n_chk++;
        if (issued != MAXI) begin n_fail++; $display("FAIL bp_issue_count: got %0d want %0d", issued, MAXI); end
        n_chk++;
        if (req_ready !== 4'd0) begin n_fail++; $display("FAIL bp_blocked: got %b want 0000", req_ready); end
        for (int c = 0; c < 60; c++) begin
            drive((c < 12) ? 4'b0011 : 4'b0000, 1'b1, 1'b0, 2'd0, 32'd0, 4'd0, 1'b0, rnd128());
            n_chk++;
            if (req_ready !== exp_gnt) begin n_fail++; $display("FAIL bp_regrant: got %b want %b", req_ready, exp_gnt); end
            if (req_ready != 4'd0) issued++;
            if (out_valid) begin
                popped++;
                n_chk++;
                if (sb.size() == 0 || {out_ch, out_data} !== sb[0]) begin
                    n_fail++; $display("FAIL bp_result: got ch=%0d data=%h", out_ch, out_data);
                end
            end
            advance();
        end
        n_chk++;
        if (popped != issued) begin n_fail++; $display("FAIL bp_lost: got %0d results want %0d", popped, issued); end
    endtask

    task automatic test_cfg_race();
        logic [31:0] m0a;
        m0a = $urandom;
        drive(4'd0, 1'b1, 1'b1, 2'd2, m0a, 4'd9, 1'b0, rnd128());
        advance();
        drive(4'b0100, 1'b1, 1'b1, 2'd2, $urandom, 4'd3, 1'b0, rnd128());
        n_chk++;
        if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL cfg_grant: got %b want 0100", req_ready); end
        advance();
        drive(4'b0100, 1'b1, 1'b0, 2'd0, 32'd0, 4'd0, 1'b0, rnd128());
        n_chk++;
        if ({rq_valid_o, rq_m0_o, rq_n_o} !== {1'b1, m0a, 4'd9}) begin
            n_fail++; $display("FAIL cfg_old: got v=%b m0=%h n=%0d want v=1 m0=%h n=9", rq_valid_o, rq_m0_o, rq_n_o, m0a);
        end
        advance();
        drive(4'd0, 1'b1, 1'b0, 2'd0, 32'd0, 4'd0, 1'b0, rnd128());
        n_chk++;
        if ({rq_valid_o, rq_n_o} !== {1'b1, 4'd3}) begin
            n_fail++; $display("FAIL cfg_new: got v=%b n=%0d want v=1 n=3", rq_valid_o, rq_n_o);
        end
        advance();
        for (int c = 0; c < 40 && sb.size() > 0; c++) begin
            drive(4'd0, 1'b1, 1'b0, 2'd0, 32'd0, 4'd0, 1'b0, rnd128());
            advance();
        end
    endtask

    task automatic test_orphan();
        drive(4'd0, 1'b1, 1'b0, 2'd0, 32'd0, 4'd0, 1'b0, rnd128());
        n_chk++;
        if (err !== 1'b0) begin n_fail++; $display("FAIL orphan_pre: got err=%b want 0", err); end
        advance();
        drive(4'd0, 1'b1, 1'b0, 2'd0, 32'd0, 4'd0, 1'b1, rnd128());
        advance();
        for (int c = 0; c < 4; c++) begin
            drive(4'd0, 1'b1, 1'b0, 2'd0, 32'd0, 4'd0, 1'b0, rnd128());
            n_chk++;
            if ({err, out_valid} !== {m_err, 1'b0}) begin
                n_fail++; $display("FAIL orphan_err: got err=%b ov=%b want err=%b ov=0", err, out_valid, m_err);
            end
            advance();
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            drive(4'($urandom), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) == 0),
                  2'($urandom), $urandom, 4'($urandom), 1'b0, rnd128());
            n_chk++;
            if (req_ready !== exp_gnt) begin n_fail++; $display("FAIL rnd_grant: got %b want %b", req_ready, exp_gnt); end
            n_chk++;
            if (rq_valid_o !== m_rq_v) begin n_fail++; $display("FAIL rnd_rqv: got %b want %b", rq_valid_o, m_rq_v); end
            if (m_rq_v) begin
                n_chk++;
                if ({rq_data_o, rq_m0_o, rq_n_o} !== {m_rq_d, m_rq_m0, m_rq_n}) begin
                    n_fail++; $display("FAIL rnd_issue: got %h/%h/%h want %h/%h/%h",
                                       rq_data_o, rq_m0_o, rq_n_o, m_rq_d, m_rq_m0, m_rq_n);
                end
            end
            if (out_valid && out_ready) begin
                n_chk++;
                if (sb.size() == 0 || {out_ch, out_data} !== sb[0]) begin
                    n_fail++; $display("FAIL rnd_result: got ch=%0d data=%h", out_ch, out_data);
                end
            end
            advance();
        end
    endtask

    task automatic test_reset_midflight();
        int issued;
        for (int c = 0; c < 3; c++) begin
            drive(4'b0001, 1'b0, 1'b0, 2'd0, 32'd0, 4'd0, 1'b0, rnd128());
            advance();
        end
        @(negedge clk);
        req_valid = 4'd0; out_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_chk++;
        if ({req_ready, rq_valid_o, rq_data_o, rq_m0_o, rq_n_o, out_valid, out_data, out_ch, err, rq_ready_o}
            !== {4'd0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b0, 8'd0, 2'd0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL midreset_state: got rdy=%b rqv=%b d=%h m0=%h n=%h ov=%b od=%h oc=%h err=%b",
                     req_ready, rq_valid_o, rq_data_o, rq_m0_o, rq_n_o, out_valid, out_data, out_ch, err);
        end
        model_reset();
        @(negedge clk); rst_n = 1'b1;
        drive(4'b0011, 1'b0, 1'b0, 2'd0, 32'd0, 4'd0, 1'b0, rnd128());
        n_chk++;
        if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL midreset_first: got %b want 0001", req_ready); end
        issued = (req_ready != 4'd0) ? 1 : 0;
        advance();
        for (int c = 0; c < 8; c++) begin
            drive(4'b1111, 1'b0, 1'b0, 2'd0, 32'd0, 4'd0, 1'b0, rnd128());
            n_chk++;
            if (req_ready !== exp_gnt) begin n_fail++; $display("FAIL midreset_grant: got %b want %b", req_ready, exp_gnt); end
            if (req_ready != 4'd0) issued++;
            advance();
        end
        n_chk++;
        if (issued != MAXI) begin n_fail++; $display("FAIL midreset_credit: got %0d issues want %0d", issued, MAXI); end
        for (int c = 0; c < 40 && sb.size() > 0; c++) begin
            drive(4'd0, 1'b1, 1'b0, 2'd0, 32'd0, 4'd0, 1'b0, rnd128());
            if (out_valid) begin
                n_chk++;
                if (sb.size() == 0 || {out_ch, out_data} !== sb[0]) begin
                    n_fail++; $display("FAIL midreset_result: got ch=%0d data=%h", out_ch, out_data);
                end
            end
            advance();
        end
        n_chk++;
        if (sb.size() != 0) begin n_fail++; $display("FAIL midreset_drain: got %0d pending want 0", sb.size()); end
    endtask

    initial begin
        test_reset();
        test_single_issue();
        test_round_robin();
        test_backpressure();
        test_cfg_race();
        test_orphan();
        test_random();
        test_reset_midflight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
